// File: rtl/strand_mem_arbiter.sv
// rtl/strand_mem_arbiter.sv - round-robin arbiter sharing one pixel RAM among strand drivers
module strand_mem_arbiter #(
    parameter int STRAND_SEL_WIDTH   = 2,
    parameter int STRAND_PARAM_WIDTH = 16,
    parameter int MEM_DATA_WIDTH     = 24,
    localparam int NUM_STRANDS       = 2 ** STRAND_SEL_WIDTH,
    localparam int MEM_ADDR_WIDTH    = STRAND_SEL_WIDTH + STRAND_PARAM_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NUM_STRANDS-1:0]                    req_valid,
    input  logic [NUM_STRANDS*STRAND_PARAM_WIDTH-1:0] req_idx,
    output logic [NUM_STRANDS-1:0]                    req_ready,
    output logic                                      mem_rd_en,
    output logic [MEM_ADDR_WIDTH-1:0]                 mem_addr,
    input  logic [MEM_DATA_WIDTH-1:0]                 mem_rd_data,
    output logic [NUM_STRANDS-1:0]                    rsp_valid,
    output logic [MEM_DATA_WIDTH-1:0]                 rsp_data
);

    logic [STRAND_SEL_WIDTH-1:0]   last_grant;
    logic [STRAND_SEL_WIDTH-1:0]   winner;
    logic [STRAND_SEL_WIDTH-1:0]   cand;
    logic [NUM_STRANDS-1:0]        grant_oh;
    logic                          found;
    logic                          handshake;
    logic [STRAND_PARAM_WIDTH-1:0] idx_arr [NUM_STRANDS];

    logic [STRAND_SEL_WIDTH-1:0]   s1_strand;
    logic                          s2_valid;
    logic [STRAND_SEL_WIDTH-1:0]   s2_strand;

    always_comb begin
        for (int i = 0; i < NUM_STRANDS; i++) begin
            idx_arr[i] = req_idx[i*STRAND_PARAM_WIDTH +: STRAND_PARAM_WIDTH];
        end
    end

    // Search starts one past the last winner; the final candidate wraps back to last_grant itself.
    always_comb begin
        grant_oh = '0;
        winner   = '0;
        found    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_STRANDS; k++) begin
            cand = last_grant + STRAND_SEL_WIDTH'(k);
            if (!found && req_valid[cand]) begin
                grant_oh[cand] = 1'b1;
                winner         = cand;
                found          = 1'b1;
            end
        end
    end

    assign req_ready = rst_n ? grant_oh : '0;
    assign handshake = rst_n & found;

    // Three fixed stages: address issue, RAM access, response register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= '1;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            s1_strand  <= '0;
            s2_valid   <= 1'b0;
            s2_strand  <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
        end else begin
            mem_rd_en <= handshake;
            if (handshake) begin
                last_grant <= winner;
                mem_addr   <= {winner, idx_arr[winner]};
                s1_strand  <= winner;
            end
            s2_valid  <= mem_rd_en;
            s2_strand <= s1_strand;
            rsp_valid <= s2_valid ? (NUM_STRANDS'(1) << s2_strand) : '0;
            if (s2_valid) begin
                rsp_data <= mem_rd_data;
            end
        end
    end

endmodule
